// File: rtl/move_cmd_if.sv
// Command handshake between the move scheduler (master) and the block datapath (slave).
interface move_cmd_if;
   logic       cmd_valid;
   logic [1:0] cmd_op;
   logic       cmd_ready;

   modport master (output cmd_valid, output cmd_op, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/move_scheduler.sv
// Turns button levels, gravity ticks and game control into a single stream of motion
// commands for the block datapath, one command in flight at a time.
module move_scheduler #(
   parameter int DEPTH           = 4,
   parameter int BASE_PERIOD     = 1000,
   parameter int MIN_PERIOD      = 50,
   parameter int LINES_PER_LEVEL = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_i,
   input  logic       game_over_i,
   input  logic       left_i,
   input  logic       right_i,
   input  logic       rotate_i,
   input  logic       row_cleared_i,
   move_cmd_if.master cmd,
   output logic [3:0] level_o,
   output logic [2:0] fifo_count_o,
   output logic       overflow_o,
   output logic       running_o
);

   typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [15:0] START_PERIOD =
      (BASE_PERIOD < MIN_PERIOD) ? 16'(MIN_PERIOD) : 16'(BASE_PERIOD);

   state_t        state_q, state_d;
   logic          left_q, right_q, rot_q;
   logic [3:0]    level_q, level_d;
   logic [7:0]    lines_q, lines_d;
   logic [15:0]   grav_q, grav_d, period_q, period_d;
   logic          dropPend_q, dropPend_d;
   logic          valid_q, valid_d, srcDrop_q, srcDrop_d;
   logic [1:0]    op_q, op_d;
   logic          overflow_q, overflow_d;
   logic [2:0]    count_q, count_d;
   logic [PW-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d, headIdx;
   logic [1:0]    mem_q [DEPTH];

   logic          inRun, accept, popNow, retireDrop, pushReq, pushOk, full, wrap, memWe;
   logic [1:0]    pushOp;
   logic [15:0]   shifted, periodNext;

   function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Next-state logic: start overrides everything, then the RUN->OVER exit, then normal play.
   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      lines_d    = lines_q;
      grav_d     = grav_q;
      period_d   = period_q;
      dropPend_d = dropPend_q;
      valid_d    = valid_q;
      op_d       = op_q;
      srcDrop_d  = srcDrop_q;
      overflow_d = overflow_q;
      count_d    = count_q;
      rdPtr_d    = rdPtr_q;
      wrPtr_d    = wrPtr_q;
      memWe      = 1'b0;
      headIdx    = rdPtr_q;

      inRun      = (state_q == RUN);
      accept     = valid_q & cmd.cmd_ready;
      popNow     = accept & ~srcDrop_q;
      retireDrop = accept & srcDrop_q;
      pushReq    = inRun & ((rotate_i & ~rot_q) | ((left_i & ~left_q) ^ (right_i & ~right_q)));
      pushOp     = (rotate_i & ~rot_q) ? 2'b11 : ((left_i & ~left_q) ? 2'b01 : 2'b10);
      full       = (count_q == 3'(DEPTH));
      pushOk     = pushReq & (~full | popNow);
      wrap       = inRun & (grav_q >= period_q - 16'd1);
      shifted    = START_PERIOD >> level_q;
      periodNext = (shifted < 16'(MIN_PERIOD)) ? 16'(MIN_PERIOD) : shifted;

      if (start_i) begin
         state_d    = RUN;
         level_d    = '0;
         lines_d    = '0;
         grav_d     = '0;
         period_d   = START_PERIOD;
         dropPend_d = 1'b0;
         valid_d    = 1'b0;
         op_d       = 2'b00;
         srcDrop_d  = 1'b0;
         overflow_d = 1'b0;
         count_d    = '0;
         rdPtr_d    = '0;
         wrPtr_d    = '0;
      end else if (inRun && game_over_i) begin
         state_d    = OVER;
         grav_d     = '0;
         dropPend_d = 1'b0;
         valid_d    = 1'b0;
         op_d       = 2'b00;
         srcDrop_d  = 1'b0;
         count_d    = '0;
         rdPtr_d    = '0;
         wrPtr_d    = '0;
      end else if (inRun) begin
         // A new period is only picked up at a wrap so the tick in progress is never cut short.
         if (wrap) begin
            grav_d   = '0;
            period_d = periodNext;
         end else begin
            grav_d = grav_q + 16'd1;
         end
         dropPend_d = (dropPend_q & ~retireDrop) | wrap;

         if (row_cleared_i) begin
            if (lines_q >= 8'(LINES_PER_LEVEL - 1)) begin
               lines_d = '0;
               if (level_q != 4'hF) level_d = level_q + 4'd1;
            end else begin
               lines_d = lines_q + 8'd1;
            end
         end

         if (popNow) rdPtr_d = ptrInc(rdPtr_q);
         if (pushOk) begin
            memWe   = 1'b1;
            wrPtr_d = ptrInc(wrPtr_q);
         end
         if (pushReq && !pushOk) overflow_d = 1'b1;
         count_d = count_q + 3'(pushOk) - 3'(popNow);

         // Issue only from what remains after this cycle's retirement; drops outrank buttons.
         if (!valid_q || accept) begin
            headIdx = popNow ? ptrInc(rdPtr_q) : rdPtr_q;
            if (dropPend_q && !retireDrop) begin
               valid_d   = 1'b1;
               op_d      = 2'b00;
               srcDrop_d = 1'b1;
            end else if ((count_q - 3'(popNow)) != 3'd0) begin
               valid_d   = 1'b1;
               op_d      = mem_q[headIdx];
               srcDrop_d = 1'b0;
            end else begin
               valid_d   = 1'b0;
               op_d      = 2'b00;
               srcDrop_d = 1'b0;
            end
         end
      end
   end

   // State registers; button history is sampled every cycle regardless of game state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         left_q     <= 1'b0;
         right_q    <= 1'b0;
         rot_q      <= 1'b0;
         level_q    <= '0;
         lines_q    <= '0;
         grav_q     <= '0;
         period_q   <= START_PERIOD;
         dropPend_q <= 1'b0;
         valid_q    <= 1'b0;
         op_q       <= 2'b00;
         srcDrop_q  <= 1'b0;
         overflow_q <= 1'b0;
         count_q    <= '0;
         rdPtr_q    <= '0;
         wrPtr_q    <= '0;
      end else begin
         state_q    <= state_d;
         left_q     <= left_i;
         right_q    <= right_i;
         rot_q      <= rotate_i;
         level_q    <= level_d;
         lines_q    <= lines_d;
         grav_q     <= grav_d;
         period_q   <= period_d;
         dropPend_q <= dropPend_d;
         valid_q    <= valid_d;
         op_q       <= op_d;
         srcDrop_q  <= srcDrop_d;
         overflow_q <= overflow_d;
         count_q    <= count_d;
         rdPtr_q    <= rdPtr_d;
         wrPtr_q    <= wrPtr_d;
         if (memWe) mem_q[wrPtr_q] <= pushOp;
      end
   end

   assign cmd.cmd_valid = valid_q;
   assign cmd.cmd_op    = op_q;
   assign level_o       = level_q;
   assign fifo_count_o  = count_q;
   assign overflow_o    = overflow_q;
   assign running_o     = (state_q == RUN);

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench: one scheduler with a long gravity period for button/handshake behaviour,
// a second with a short period to observe level-dependent drop spacing.
module tb_move_scheduler;

   logic clk = 1'b0;
   logic resetA, startA, goA, leftA, rightA, rotA, rowA;
   logic resetB, startB, rowB;
   logic zeroB = 1'b0;
   logic [3:0] levelA, levelB;
   logic [2:0] countA, countB;
   logic ovfA, ovfB, runA, runB;

   int assertCount = 0;
   int failCount   = 0;
   int pulses, accepts, rotCnt, leftCnt;

   move_cmd_if ifA ();
   move_cmd_if ifB ();

   move_scheduler #(.DEPTH(4), .BASE_PERIOD(1000), .MIN_PERIOD(50), .LINES_PER_LEVEL(4)) dutA (
      .clk(clk), .reset(resetA), .start_i(startA), .game_over_i(goA),
      .left_i(leftA), .right_i(rightA), .rotate_i(rotA), .row_cleared_i(rowA),
      .cmd(ifA.master), .level_o(levelA), .fifo_count_o(countA),
      .overflow_o(ovfA), .running_o(runA));

   move_scheduler #(.DEPTH(4), .BASE_PERIOD(8), .MIN_PERIOD(3), .LINES_PER_LEVEL(4)) dutB (
      .clk(clk), .reset(resetB), .start_i(startB), .game_over_i(zeroB),
      .left_i(zeroB), .right_i(zeroB), .rotate_i(zeroB), .row_cleared_i(rowB),
      .cmd(ifB.master), .level_o(levelB), .fifo_count_o(countB),
      .overflow_o(ovfB), .running_o(runB));

   // Free-running clock shared by both instances.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drive instance A inputs, then advance one clock and settle past the edge.
   task automatic applyStimulus(input logic l, input logic r, input logic rot,
                                input logic rdy, input logic st, input logic go);
      leftA = l; rightA = r; rotA = rot;
      ifA.cmd_ready = rdy; startA = st; goA = go;
      @(posedge clk);
      #1;
   endtask

   task automatic measureGap(input string tag, input int expected);
      int seen = 0;
      int t0 = 0, t1 = 0, t2 = 0;
      int opSeen = 0;
      for (int c = 0; c < 60 && seen < 3; c++) begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         if (ifB.cmd_valid) begin
            if (seen == 0) begin t0 = c; opSeen = int'(ifB.cmd_op); end
            else if (seen == 1) t1 = c;
            else t2 = c;
            seen++;
         end
      end
      checkOutput({tag, "_found"}, seen, 3);
      checkOutput({tag, "_op"}, opSeen, 0);
      if (seen == 3) begin
         checkOutput({tag, "_gap1"}, t1 - t0, expected);
         checkOutput({tag, "_gap2"}, t2 - t1, expected);
      end
   endtask

   initial begin
      resetA = 1'b0; resetB = 1'b0; startB = 1'b0; rowB = 1'b0; rowA = 1'b0;
      ifB.cmd_ready = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("rst_valid", int'(ifA.cmd_valid), 0);
      checkOutput("rst_level", int'(levelA), 0);
      checkOutput("rst_count", int'(countA), 0);
      checkOutput("rst_running", int'(runA), 0);
      resetA = 1'b1;

      // Reset while a command is presented.
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("t1_running", int'(runA), 1);
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("t1_valid", int'(ifA.cmd_valid), 1);
      checkOutput("t1_op", int'(ifA.cmd_op), 3);
      resetA = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("t1_rvalid", int'(ifA.cmd_valid), 0);
      checkOutput("t1_rop", int'(ifA.cmd_op), 0);
      checkOutput("t1_rcount", int'(countA), 0);
      checkOutput("t1_rrunning", int'(runA), 0);
      resetA = 1'b1;

      // Held left button yields a single command.
      applyStimulus(0, 0, 0, 1, 1, 0);
      pulses = 0;
      for (int i = 0; i < 14; i++) begin
         applyStimulus(i < 10, 0, 0, 1, 0, 0);
         if (ifA.cmd_valid && ifA.cmd_op == 2'b01) pulses++;
      end
      checkOutput("t2_pulses", pulses, 1);
      checkOutput("t2_count", int'(countA), 0);

      // Five rotates into a four-deep queue while stalled, then drain.
      applyStimulus(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 1, 0, 0, 0);
         applyStimulus(0, 0, 0, 0, 0, 0);
      end
      checkOutput("t3_count", int'(countA), 4);
      checkOutput("t3_overflow", int'(ovfA), 1);
      checkOutput("t3_valid", int'(ifA.cmd_valid), 1);
      checkOutput("t3_op", int'(ifA.cmd_op), 3);
      accepts = 0;
      for (int i = 0; i < 10; i++) begin
         if (ifA.cmd_valid && ifA.cmd_op == 2'b11) accepts++;
         applyStimulus(0, 0, 0, 1, 0, 0);
      end
      checkOutput("t3_accepts", accepts, 4);
      checkOutput("t3_drained", int'(countA), 0);
      checkOutput("t3_sticky", int'(ovfA), 1);

      // Simultaneous button edges.
      applyStimulus(0, 0, 0, 1, 1, 0);
      checkOutput("t5_ovfclr", int'(ovfA), 0);
      applyStimulus(1, 1, 0, 1, 0, 0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         if (ifA.cmd_valid) pulses++;
         applyStimulus(0, 0, 0, 1, 0, 0);
      end
      checkOutput("t5_lr_cancel", pulses, 0);
      checkOutput("t5_lr_count", int'(countA), 0);
      applyStimulus(1, 0, 1, 1, 0, 0);
      rotCnt = 0; leftCnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (ifA.cmd_valid && ifA.cmd_op == 2'b11) rotCnt++;
         if (ifA.cmd_valid && ifA.cmd_op == 2'b01) leftCnt++;
         applyStimulus(0, 0, 0, 1, 0, 0);
      end
      checkOutput("t5_rot", rotCnt, 1);
      checkOutput("t5_left", leftCnt, 0);

      // Game over during a stalled handshake, then restart.
      applyStimulus(0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("t6_prevalid", int'(ifA.cmd_valid), 1);
      checkOutput("t6_precount", int'(countA), 2);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("t6_valid", int'(ifA.cmd_valid), 0);
      checkOutput("t6_count", int'(countA), 0);
      checkOutput("t6_running", int'(runA), 0);
      applyStimulus(0, 0, 1, 0, 0, 1);
      checkOutput("t6_overpush", int'(countA), 0);
      applyStimulus(0, 0, 0, 0, 1, 1);
      checkOutput("t6_restart", int'(runA), 1);
      checkOutput("t6_rvalid", int'(ifA.cmd_valid), 0);

      // Gravity spacing versus level on the short-period instance.
      applyStimulus(0, 0, 0, 0, 0, 0);
      resetB = 1'b1;
      ifB.cmd_ready = 1'b1;
      startB = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0);
      startB = 1'b0;
      checkOutput("t4_level0", int'(levelB), 0);
      measureGap("t4_l0", 8);
      rowB = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      rowB = 1'b0;
      checkOutput("t4_level1", int'(levelB), 1);
      for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      measureGap("t4_l1", 4);
      rowB = 1'b1;
      for (int i = 0; i < 64; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      rowB = 1'b0;
      checkOutput("t4_level15", int'(levelB), 15);
      for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      measureGap("t4_l15", 3);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
